// File: rtl/multiword_adder_sequencer.sv
// rtl/multiword_adder_sequencer.sv - slice-serial multi-precision adder built around one carry-lookahead adder
// Operands are captured on start and summed one WIDTH-bit slice per cycle, least significant first.

module carry_lookahead_adder #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic [WIDTH-1:0] w_g;
   logic [WIDTH-1:0] w_p;
   logic [WIDTH:0]   w_c;
   logic             w_term;
   logic             w_prop;

   assign w_g = a & b;
   assign w_p = a ^ b;

   // Each carry is formed directly from generate/propagate terms rather than the previous carry.
   always_comb begin
      w_c    = '0;
      w_term = 1'b0;
      w_prop = 1'b0;
      w_c[0] = carry_in;
      for (int i = 0; i < WIDTH; i++) begin
         w_term = w_g[i];
         w_prop = w_p[i];
         for (int j = i - 1; j >= 0; j--) begin
            w_term = w_term | (w_prop & w_g[j]);
            w_prop = w_prop & w_p[j];
         end
         w_c[i+1] = w_term | (w_prop & carry_in);
      end
   end

   assign sum       = w_p ^ w_c[WIDTH-1:0];
   assign carry_out = w_c[WIDTH];

endmodule

module multiword_adder_sequencer #(
   parameter int WIDTH = 8,
   parameter int WORDS = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [WIDTH*WORDS-1:0] a,
   input  logic [WIDTH*WORDS-1:0] b,
   input  logic                   carry_in,
   output logic                   busy,
   output logic                   done,
   output logic [WIDTH*WORDS-1:0] sum,
   output logic                   carry_out
);

   localparam int N    = WIDTH * WORDS;
   localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           r_state;
   logic [IDXW-1:0]  r_idx;
   logic [N-1:0]     r_a;
   logic [N-1:0]     r_b;
   logic [N-1:0]     r_work;
   logic             r_carry;
   logic [N-1:0]     r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic [WIDTH-1:0] w_a_slice;
   logic [WIDTH-1:0] w_b_slice;
   logic [WIDTH-1:0] w_sum_slice;
   logic             w_cout_slice;
   logic [N-1:0]     w_work_next;

   assign w_a_slice = r_a[r_idx*WIDTH +: WIDTH];
   assign w_b_slice = r_b[r_idx*WIDTH +: WIDTH];

   carry_lookahead_adder #(.WIDTH(WIDTH)) u_cla (
      .a         (w_a_slice),
      .b         (w_b_slice),
      .carry_in  (r_carry),
      .sum       (w_sum_slice),
      .carry_out (w_cout_slice)
   );

   // Working value with the current slice merged in, so the final slice reaches sum on the same edge.
   always_comb begin
      w_work_next = r_work;
      w_work_next[r_idx*WIDTH +: WIDTH] = w_sum_slice;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_work  <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= carry_in;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_work  <= w_work_next;
               r_carry <= w_cout_slice;
               if (r_idx == LAST_IDX) begin
                  r_sum   <= w_work_next;
                  r_cout  <= w_cout_slice;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_idx   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign sum       = r_sum;
   assign carry_out = r_cout;

endmodule

// File: doc/multiword_adder_sequencer.md
# multiword_adder_sequencer

Multi-precision adder controller. It adds two WORDS×WIDTH-bit operands by time-multiplexing a single WIDTH-bit `carry_lookahead_adder` over WORDS cycles, one slice per cycle, least significant slice first. The carry is registered between slices. It sits between a requester that issues `start` with full-width operands and the shared narrow adder datapath. It returns a registered full-width sum, a final carry and a one-cycle `done` pulse.

## Interface
- WIDTH, 8: slice width; passed unchanged to the internal `carry_lookahead_adder` instance.
- WORDS, 4: number of slices; must be ≥ 1. Operand width is N = WIDTH*WORDS.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  N  operand A; sampled on the accepting edge only.
- b  input  N  operand B; sampled on the accepting edge only.
- carry_in  input  1  initial carry into slice 0; sampled with a and b.
- busy  output  1  high while an operation is in progress (RUN).
- done  output  1  one-cycle pulse when sum and carry_out update.
- sum  output  N  registered result (a + b + carry_in) mod 2^N.
- carry_out  output  1  registered carry out of the most significant slice.

## Operation
- Exactly one `carry_lookahead_adder #(.WIDTH(WIDTH))` instance. Its inputs are slice `idx` of the captured A and B plus the carry register. No second adder and no full-width `+` anywhere in the block.
- States: IDLE and RUN.
- **IDLE:**
  - If start=1 at an edge: capture a, b and carry_in into operand registers and the carry register. Clear idx to 0 and go to RUN.
  - Otherwise remain in IDLE.
- **RUN**, each edge:
  - The adder's slice sum is written into slice idx of an internal working register.
  - The carry register takes the adder's carry_out.
  - idx increments.
- **Completion.** At the edge where idx == WORDS-1:
  - The working register, including this last slice, is copied to `sum`.
  - The adder's carry_out is copied to `carry_out`.
  - done goes to 1 and the state returns to IDLE.
- start while busy=1 is ignored; it is neither queued nor able to corrupt captured operands. Changes on a, b or carry_in during RUN have no effect.
- `sum` and `carry_out` change only on the edge that raises done. They hold the last completed result otherwise.
- idx width: max(1, $clog2(WORDS)). For WORDS=1, RUN lasts exactly one cycle.
- **Reset** (asynchronous, any time, including mid-operation):
  - State IDLE, idx 0, carry register 0, busy 0, done 0, sum 0, carry_out 0.
  - An aborted operation produces no done pulse.

## Timing
- Call the accepting edge E0. Slices 0..WORDS-1 are processed on edges E1..E_WORDS.
- busy is 1 from after E0 until after E_WORDS; busy = (state == RUN), registered.
- done is 1 for exactly the cycle following E_WORDS, with sum and carry_out valid in that same cycle. Latency from start being sampled to done is WORDS cycles.
- done and busy are never high together.
- The cycle in which done is high is an IDLE cycle. start=1 there is accepted at the next edge, so start held high gives a throughput of one result per WORDS+1 cycles.
- The adder path is combinational between registers. The critical path is the operand/carry registers through the WIDTH-bit adder into the working and carry registers.

## Test plan
Bench uses WIDTH=8, WORDS=4 (N=32).

- **Reset:** hold rst_n=0 with start=1 and random a, b.
  - Required: busy=0, done=0, sum=0, carry_out=0 throughout.
  - Required: after release, the first done appears exactly 4 cycles after the first accepting edge.
- **Cross-slice carry:** a=0x000000FF, b=0x00000001, carry_in=0.
  - Required: sum=0x00000100, carry_out=0, done exactly 4 cycles after E0 and high for one cycle.
- **Full ripple and carry_in:**
  - a=0xFFFFFFFF, b=0x00000001, carry_in=0 → sum=0x00000000, carry_out=1.
  - a=0xFFFFFFFF, b=0x00000000, carry_in=1 → sum=0x00000000, carry_out=1.
  - a=0x80000000, b=0x80000000 → sum=0, carry_out=1.
- **Busy protection:** start a=0x12345678, b=0x11111111. Two cycles later, pulse start with a=b=0xFFFFFFFF and change the a/b inputs.
  - Required: single done, sum=0x23456789, carry_out=0.
- **Back-to-back and abort:**
  - Hold start=1 with 3 queued operand pairs → done every 5 cycles, each result correct.
  - Then start an operation and drop rst_n after 2 slices → no done, outputs 0.
  - Then a=1, b=2 after reset → sum=3.
- **Random:** 10,000 random a, b, carry_in with random start gaps.
  - Required: every done matches {carry_out,sum} == a+b+carry_in (33-bit).
  - Required: done count equals accepted-start count.
